// File: rtl/spypath_delay_meas.sv
// Launches alternating edges into a spy path and encodes the TDC thermometer
// sampled after each edge into arrival codes with per-run count/sum/min/max.
module spypath_delay_meas #(
    parameter int TAPS     = 64,
    parameter int TRIALS_W = 8,
    parameter int SETTLE   = 4,
    parameter int SUM_W    = $clog2(TAPS + 1) + TRIALS_W,
    localparam int CW      = $clog2(TAPS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [TRIALS_W-1:0] num_trials,
    input  logic [TAPS-1:0]     tdc_taps,
    output logic                launch,
    output logic                busy,
    output logic                meas_valid,
    output logic [CW-1:0]       meas_code,
    output logic                done,
    output logic [TRIALS_W-1:0] trial_cnt,
    output logic [SUM_W-1:0]    sum_out,
    output logic [CW-1:0]       min_out,
    output logic [CW-1:0]       max_out,
    output logic                bubble_err
);

    localparam int WW = $clog2(SETTLE + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LAUNCH  = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_ENCODE  = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]          state;
    logic [TRIALS_W-1:0] n_lat;
    logic [WW-1:0]       wcnt;
    logic                pol;
    logic [TAPS-1:0]     cap;
    logic [CW-1:0]       code_c;
    logic                bub_c;
    logic                found;
    logic                last_c;

    // code = index of the first zero; any one above it is a bubble
    always_comb begin
        code_c = CW'(TAPS);
        bub_c  = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < TAPS; i++) begin
            if (found) begin
                if (cap[i]) bub_c = 1'b1;
            end else if (!cap[i]) begin
                found  = 1'b1;
                code_c = CW'(i);
            end
        end
    end

    assign last_c = (trial_cnt + TRIALS_W'(1)) == n_lat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            n_lat      <= '0;
            wcnt       <= '0;
            pol        <= 1'b0;
            cap        <= '0;
            launch     <= 1'b0;
            busy       <= 1'b0;
            meas_valid <= 1'b0;
            meas_code  <= '0;
            done       <= 1'b0;
            trial_cnt  <= '0;
            sum_out    <= '0;
            min_out    <= '0;
            max_out    <= '0;
            bubble_err <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            done       <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    // busy still high here means the done cycle just ended
                    if (busy) begin
                        busy <= 1'b0;
                    end else if (start) begin
                        busy       <= 1'b1;
                        n_lat      <= num_trials;
                        trial_cnt  <= '0;
                        sum_out    <= '0;
                        bubble_err <= 1'b0;
                        max_out    <= '0;
                        if (num_trials == '0) begin
                            min_out <= '0;
                            done    <= 1'b1;
                        end else begin
                            min_out <= '1;
                            launch  <= ~launch;
                            pol     <= ~launch;
                            state   <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    wcnt  <= WW'(SETTLE);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (wcnt == WW'(1)) state <= S_CAPTURE;
                    else wcnt <= wcnt - WW'(1);
                end
                S_CAPTURE: begin
                    cap   <= pol ? tdc_taps : ~tdc_taps;
                    state <= S_ENCODE;
                end
                S_ENCODE: begin
                    meas_valid <= 1'b1;
                    meas_code  <= code_c;
                    trial_cnt  <= trial_cnt + TRIALS_W'(1);
                    sum_out    <= sum_out + SUM_W'(code_c);
                    if (code_c < min_out) min_out <= code_c;
                    if (code_c > max_out) max_out <= code_c;
                    if (bub_c) bubble_err <= 1'b1;
                    if (last_c) begin
                        state <= S_DONE;
                    end else begin
                        launch <= ~launch;
                        pol    <= ~launch;
                        state  <= S_LAUNCH;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spypath_delay_meas.sv
// Randomised bench for spypath_delay_meas: a spy-path stand-in drives the
// taps per launch edge, and a queue-based model predicts every result.
module tb_spypath_delay_meas;

    localparam int TAPS     = 64;
    localparam int TRIALS_W = 8;
    localparam int SETTLE   = 4;
    localparam int CW       = 7;
    localparam int SUM_W    = 15;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [TRIALS_W-1:0] num_trials = '0;
    logic [TAPS-1:0]     tdc_taps = '0;
    logic                launch;
    logic                busy;
    logic                meas_valid;
    logic [CW-1:0]       meas_code;
    logic                done;
    logic [TRIALS_W-1:0] trial_cnt;
    logic [SUM_W-1:0]    sum_out;
    logic [CW-1:0]       min_out;
    logic [CW-1:0]       max_out;
    logic                bubble_err;

    spypath_delay_meas #(
        .TAPS(TAPS),
        .TRIALS_W(TRIALS_W),
        .SETTLE(SETTLE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .num_trials(num_trials),
        .tdc_taps(tdc_taps),
        .launch(launch),
        .busy(busy),
        .meas_valid(meas_valid),
        .meas_code(meas_code),
        .done(done),
        .trial_cnt(trial_cnt),
        .sum_out(sum_out),
        .min_out(min_out),
        .max_out(max_out),
        .bubble_err(bubble_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] pat_q[$];
    logic [63:0] dir_q[$];
    int run_n = 0;
    int m_cnt = 0;
    int m_sum = 0;
    int m_min = 0;
    int m_max = 0;
    bit m_bub = 0;
    bit done_due = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int mv_first = -1;
    int done_lat = -1;
    int last_tog = -1;
    int tog_cnt = 0;
    int tog_start = 0;
    bit last_l = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int code_of(input logic [63:0] p);
        int c = 64;
        for (int i = 63; i >= 0; i--)
            if (!p[i]) c = i;
        return c;
    endfunction

    function automatic bit bub_of(input logic [63:0] p);
        int c = code_of(p);
        for (int i = c + 1; i < 64; i++)
            if (p[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [63:0] rand_pat();
        int k = $urandom_range(0, 64);
        logic [63:0] ones = '1;
        logic [63:0] p;
        p = ones >> (64 - k);
        if ($urandom_range(0, 3) == 0)
            p = p | ({$urandom, $urandom} << (k + 1));
        return p;
    endfunction

    always @(posedge clk) cyc++;

    // spy-path stand-in: new arrival pattern per launch edge
    always @(negedge clk) begin : gen
        logic [63:0] p;
        if (rst) begin
            pat_q.delete();
            last_l = 1'b0;
        end else if (launch !== last_l) begin
            last_l = launch;
            tog_cnt++;
            if (last_tog >= 0) chk("launch_gap", cyc - last_tog, SETTLE + 3);
            last_tog = cyc;
            p = (dir_q.size() != 0) ? dir_q.pop_front() : rand_pat();
            tdc_taps = launch ? p : ~p;
            pat_q.push_back(p);
        end
    end

    always @(negedge clk) begin : cmp
        logic [63:0] p;
        int c;
        if (rst) begin
            done_due = 1'b0;
        end else begin
            chk("done", done, done_due);
            if (done && done_due) begin
                done_lat = cyc - acc_cyc;
                chk("busy_at_done", busy, 1);
                chk("cnt_at_done", trial_cnt, m_cnt);
                chk("sum_at_done", sum_out, m_sum);
                chk("min_at_done", min_out, m_min);
                chk("max_at_done", max_out, m_max);
                chk("bub_at_done", bubble_err, m_bub);
            end
            done_due = 1'b0;
            if (meas_valid) begin
                if (pat_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL meas_valid: got pulse, expected none");
                end else begin
                    p = pat_q.pop_front();
                    c = code_of(p);
                    m_cnt++;
                    m_sum += c;
                    if (m_cnt == 1 || c < m_min) m_min = c;
                    if (c > m_max) m_max = c;
                    m_bub = m_bub | bub_of(p);
                    if (mv_first < 0) mv_first = cyc - acc_cyc;
                    chk("meas_code", meas_code, c);
                    chk("trial_cnt", trial_cnt, m_cnt);
                    chk("sum_out", sum_out, m_sum);
                    chk("min_out", min_out, m_min);
                    chk("max_out", max_out, m_max);
                    chk("bubble_err", bubble_err, m_bub);
                    if (m_cnt == run_n) done_due = 1'b1;
                end
            end
        end
    end

    task automatic run(input int n, input bit stray);
        bit got = 0;
        int budget = (n + 2) * (SETTLE + 3) + 10;
        @(negedge clk);
        start = 1'b1;
        num_trials = n[TRIALS_W-1:0];
        @(posedge clk);
        #1;
        start = 1'b0;
        acc_cyc = cyc;
        run_n = n;
        m_cnt = 0;
        m_sum = 0;
        m_min = (n == 0) ? 0 : 127;
        m_max = 0;
        m_bub = 1'b0;
        mv_first = -1;
        done_lat = -1;
        last_tog = -1;
        tog_start = tog_cnt;
        if (n == 0) done_due = 1'b1;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            #1;
            if (done) got = 1'b1;
            if (stray && i == 9) begin
                start = 1'b1;
                num_trials = 8'd9;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_timeout: got no done, expected done for n=%0d", n);
        end
        repeat (2) @(negedge clk);
        chk("launch_toggles", tog_cnt - tog_start, n);
        chk("busy_after", busy, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_launch"}, launch, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_mv"}, meas_valid, 0);
        chk({tag, "_code"}, meas_code, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_cnt"}, trial_cnt, 0);
        chk({tag, "_sum"}, sum_out, 0);
        chk({tag, "_min"}, min_out, 0);
        chk({tag, "_max"}, max_out, 0);
        chk({tag, "_bub"}, bubble_err, 0);
    endtask

    initial begin
        bit saved_l;
        bit hit;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        dir_q.push_back(64'hFF);
        run(1, 0);
        chk("t1_sum", sum_out, 8);
        chk("t1_min", min_out, 8);
        chk("t1_max", max_out, 8);
        chk("t1_bub", bubble_err, 0);
        chk("t1_mv_latency", mv_first, SETTLE + 3);
        chk("t1_done_latency", done_lat, SETTLE + 4);
        chk("t1_launch", launch, 1);

        dir_q.push_back(64'hFFF);
        dir_q.push_back(64'hF_FFFF);
        dir_q.push_back(64'hFFF);
        dir_q.push_back(64'hF_FFFF);
        run(4, 0);
        chk("t2_sum", sum_out, 64);
        chk("t2_min", min_out, 12);
        chk("t2_max", max_out, 20);
        chk("t2_cnt", trial_cnt, 4);

        dir_q.push_back(64'hB7);
        run(1, 0);
        chk("t3_code", meas_code, 3);
        chk("t3_bub", bubble_err, 1);
        repeat (5) @(negedge clk);
        chk("t3_bub_sticky", bubble_err, 1);

        dir_q.push_back('1);
        dir_q.push_back(64'h0);
        run(2, 0);
        chk("t4_sum", sum_out, 64);
        chk("t4_min", min_out, 0);
        chk("t4_max", max_out, 64);
        chk("t4_bub_cleared", bubble_err, 0);

        saved_l = launch;
        run(0, 0);
        chk("t5_sum", sum_out, 0);
        chk("t5_min", min_out, 0);
        chk("t5_max", max_out, 0);
        chk("t5_cnt", trial_cnt, 0);
        chk("t5_done_latency", done_lat, 0);
        chk("t5_launch_held", launch, saved_l);

        run(3, 1);
        chk("t6_cnt", trial_cnt, 3);

        // abort during the WAIT of trial 2
        @(negedge clk);
        start = 1'b1;
        num_trials = 8'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        acc_cyc = cyc;
        run_n = 5;
        m_cnt = 0;
        m_sum = 0;
        m_min = 127;
        m_max = 0;
        m_bub = 1'b0;
        mv_first = -1;
        last_tog = -1;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (m_cnt == 1) hit = 1'b1;
        end
        chk("t7_first_trial", hit, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk_reset_vals("abort");
        rst = 1'b0;
        m_cnt = 0;
        m_sum = 0;
        m_min = 0;
        m_max = 0;
        m_bub = 1'b0;
        repeat (12) @(negedge clk);
        chk("t7_no_done_busy", busy, 0);
        run(3, 0);
        chk("t7_rerun_cnt", trial_cnt, 3);

        for (int r = 0; r < 12; r++)
            run($urandom_range(1, 10), $urandom_range(0, 1) == 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
